// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link: the capture FSM states and the default
// counter width used by both the generator and the capture block.
package pwm_pkg;

   localparam int PWM_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Bundle of the PWM input and measurement results between the capture block
// (master) and whoever consumes the measurements (slave).
interface pwm_capture_if
   import pwm_pkg::*;
#(
   parameter int W = PWM_W_DEFAULT
);

   logic         pwm_in;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         timeout;
   logic         level;

   modport master (
      input  pwm_in,
      output period,
      output high_time,
      output valid,
      output timeout,
      output level
   );

   modport slave (
      output pwm_in,
      input  period,
      input  high_time,
      input  valid,
      input  timeout,
      input  level
   );

endinterface

// File: rtl/pwm_capture_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with asynchronous
// active-low reset so both stages come up at 0.
module sync_2ff (
   input  logic ck,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in ck cycles,
// publishing one result per input period and flagging a stuck input.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int W = PWM_W_DEFAULT
) (
   input  logic           ck,
   input  logic           rst_n,
   pwm_capture_if.master  bus
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic         s2;
   logic         s3_q;
   logic         rise;
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] hcnt_q;
   logic [W-1:0] hcnt_d;

   pwm_state_e   state_q;
   logic [W-1:0] period_q;
   logic [W-1:0] high_q;
   logic         valid_q;
   logic         timeout_q;

   sync_2ff u_sync (
      .ck    (ck),
      .rst_n (rst_n),
      .d_i   (bus.pwm_in),
      .q_o   (s2)
   );

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         s3_q <= 1'b0;
      end else begin
         s3_q <= s2;
      end
   end

   assign rise = s2 & ~s3_q;

   // Both counters restart at 1 on a rising edge so the value seen at the next
   // edge equals the cycles elapsed; saturation keeps a stuck input detectable.
   always_comb begin
      cnt_d  = cnt_q;
      hcnt_d = hcnt_q;
      if (rise) begin
         cnt_d  = CNT_ONE;
         hcnt_d = CNT_ONE;
      end else begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (s2 && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         hcnt_q <= hcnt_d;
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_q <= cnt_q;
                  high_q   <= hcnt_q;
                  valid_q  <= 1'b1;
               end else if (cnt_q == CNT_MAX) begin
                  state_q   <= TIMEOUT;
                  period_q  <= '0;
                  high_q    <= '0;
                  timeout_q <= 1'b1;
               end
            end
            TIMEOUT: begin
               // The interval ending here began at an unknown time, so no result.
               if (rise) begin
                  state_q   <= MEASURE;
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.period    = period_q;
   assign bus.high_time = high_q;
   assign bus.valid     = valid_q;
   assign bus.timeout   = timeout_q;
   assign bus.level     = s2;

endmodule
